shadow_stack_cfi: RTL

SHADOW_STACK_CFI -- requirements
Module: shadow_stack_cfi

---
 rtl/ariane_pkg.sv | 21 ++
 rtl/shadow_stack_mem.sv | 64 ++++++
 rtl/shadow_stack_cfi.sv | 111 +++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared definitions for the front-end control-flow integrity logic:
// default shadow-stack depth and the resolved control-flow event encoding.
package ariane_pkg;

  localparam int unsigned SS_DEPTH = 16;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    CALL    = 2'b01,
    RET     = 2'b10,
    CALLRET = 2'b11
  } cf_event_e;

  // Classify a branch-unit resolve; nothing happens unless the resolve is valid.
  function automatic cf_event_e decode_cf(input logic valid, input logic is_call,
                                          input logic is_return);
    if (!valid) return NONE;
    return cf_event_e'({is_return, is_call});
  endfunction

endpackage

// File: rtl/shadow_stack_mem.sv
// Circular LIFO of return addresses. A push onto a full stack overwrites the
// oldest entry and reports it on wrap_o; replace rewrites the current top.
module shadow_stack_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned VLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       replace_i,
  input  logic [VLEN-1:0]            data_i,
  output logic [VLEN-1:0]            top_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       wrap_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full;

  // ptr_q is the next free slot; the top lives one below it, modulo DEPTH.
  assign top_idx = ptr_q - PW'(1);
  assign full    = (cnt_q == CW'(DEPTH));
  assign wrap_o  = push_i & full;
  assign top_o   = mem_q[top_idx];
  assign count_o = cnt_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop_i) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[ptr_q] <= data_i;
    end else if (replace_i) begin
      mem_q[top_idx] <= data_i;
    end
  end

endmodule

// File: rtl/shadow_stack_cfi.sv
// Return-address shadow stack: records call links, compares returns against
// them, and raises a one-cycle mismatch pulse plus a sticky crash flag.
module shadow_stack_cfi
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = SS_DEPTH,
  parameter int unsigned VLEN  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   resolve_valid_i,
  input  logic                   is_call_i,
  input  logic                   is_return_i,
  input  logic [VLEN-1:0]        pc_i,
  input  logic                   is_compressed_i,
  input  logic [VLEN-1:0]        target_i,
  input  logic                   en_check_i,
  input  logic                   clear_i,
  output logic                   mismatch_o,
  output logic                   crash_o,
  output logic [VLEN-1:0]        bad_pc_o,
  output logic [$clog2(DEPTH):0] depth_o,
  output logic                   overflow_o
);

  cf_event_e                ev;
  logic [VLEN-1:0]          link;
  logic [VLEN-1:0]          top_entry;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty, wrap;
  logic                     push, pop, replace, viol, hit;

  logic                     mismatch_q, crash_q, overflow_q;
  logic [VLEN-1:0]          bad_pc_q;

  assign ev    = decode_cf(resolve_valid_i, is_call_i, is_return_i);
  assign link  = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
  assign empty = (count == '0);

  // An empty-stack return is only a violation if no entry was ever lost to wrap.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    viol    = 1'b0;
    if (!clear_i) begin
      unique case (ev)
        CALL: push = 1'b1;
        RET: begin
          if (!empty) begin
            pop  = 1'b1;
            viol = (top_entry != target_i);
          end else begin
            viol = ~overflow_q;
          end
        end
        CALLRET: begin
          if (!empty) begin
            replace = 1'b1;
            viol    = (top_entry != target_i);
          end else begin
            push = 1'b1;
            viol = ~overflow_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit = viol & en_check_i;

  shadow_stack_mem #(
    .DEPTH (DEPTH),
    .VLEN  (VLEN)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .push_i    (push),
    .pop_i     (pop),
    .replace_i (replace),
    .data_i    (link),
    .top_o     (top_entry),
    .count_o   (count),
    .wrap_o    (wrap)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      mismatch_q <= 1'b0;
      crash_q    <= 1'b0;
      overflow_q <= 1'b0;
      bad_pc_q   <= '0;
    end else begin
      mismatch_q <= hit;
      if (hit && !crash_q) begin
        crash_q  <= 1'b1;
        bad_pc_q <= pc_i;
      end
      if (wrap) overflow_q <= 1'b1;
    end
  end

  assign mismatch_o = mismatch_q;
  assign crash_o    = crash_q;
  assign overflow_o = overflow_q;
  assign bad_pc_o   = bad_pc_q;
  assign depth_o    = count;

endmodule
